// File: rtl/score_bcd_converter_if.sv
// Start/done handshake and result bus of the score binary-to-BCD converter.
interface score_bcd_converter_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow
    );
endinterface

// File: rtl/score_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional macro LEADING_BLANK_EN replaces leading zero digits with 4'hF (blank).
module score_bcd_converter #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    score_bcd_converter_if.slave  bus
);
    localparam int SCR_W = 4 * (DIGITS + 1);
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    if ((64'd1 << BIN_W) > pow10(DIGITS + 1)) begin : g_width_check
        $error("score_bcd_converter: 2**BIN_W exceeds 10**(DIGITS+1)");
    end

`ifdef LEADING_BLANK_EN
    localparam logic [4*DIGITS-1:0] BCD_RST = {{(DIGITS-1){4'hF}}, 4'h0};
`else
    localparam logic [4*DIGITS-1:0] BCD_RST = '0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q,    state_d;
    logic [BIN_W-1:0]     shreg_q,    shreg_d;
    logic [SCR_W-1:0]     scratch_q,  scratch_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;
    logic                 overflow_q, overflow_d;
    logic [4*DIGITS-1:0]  bcd_q,      bcd_d;

    logic [SCR_W-1:0]     adj;
    logic [3:0]           nib;
    logic [4*DIGITS-1:0]  res;
`ifdef LEADING_BLANK_EN
    logic                 lead;
`endif

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        bcd_d      = bcd_q;
        adj        = scratch_q;
        nib        = '0;
        res        = scratch_q[4*DIGITS-1:0];
`ifdef LEADING_BLANK_EN
        lead       = 1'b1;
`endif

        // Add-3 correction is evaluated on every nibble in parallel, guard included.
        for (int unsigned i = 0; i < DIGITS + 1; i++) begin
            nib = scratch_q[4*i +: 4];
            adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end

`ifdef LEADING_BLANK_EN
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            if (lead && res[4*i +: 4] == 4'h0) res[4*i +: 4] = 4'hF;
            else                                lead = 1'b0;
        end
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shreg_d   = bus.bin;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BIN_W);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shreg_d} = {adj, shreg_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                if (scratch_q[4*DIGITS +: 4] != 4'h0) begin
                    bcd_d      = {DIGITS{4'h9}};
                    overflow_d = 1'b1;
                end else begin
                    bcd_d      = res;
                    overflow_d = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= BCD_RST;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            bcd_q      <= bcd_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = overflow_q;
endmodule
